// File: rtl/fetch_unit.sv
// Instruction fetch/decode sequencer: fetches one word per PC address over req/ack,
// latches it into the IR and pulses the PC increment/load controls.
//
// state    | meaning
// S_IDLE   | quiet, waiting for run
// S_REQ    | mem_req high, waiting for mem_ack (bounded by TIMEOUT)
// S_DECODE | one cycle: ir_valid plus pc_inc or pc_load (neither for HALT)
// S_HALT   | HALT executed, sticky until reset
// S_FAULT  | memory timeout, sticky until reset
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic               zero_flag,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               halted,
    output logic               fault
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DECODE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             ir_load;
    logic [3:0]       opcode;

    assign opcode    = ir[15:12];
    assign mem_addr  = pc_addr;
    assign pc_target = ADDR_W'(ir[7:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ir       <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (ir_load) begin
                ir <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        ir_load      = 1'b0;
        mem_req      = 1'b0;
        ir_valid     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                // an ack on the final allowed cycle still completes the fetch
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                ir_valid = 1'b1;
                case (opcode)
                    OP_JMP:  pc_load = 1'b1;
                    OP_JZ: begin
                        pc_load = zero_flag;
                        pc_inc  = !zero_flag;
                    end
                    OP_HALT: ;
                    default: pc_inc = 1'b1;
                endcase
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (run) begin
                    state_nxt = S_REQ;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM responder feeds a scoreboard of fetched words,
// a monitor checks each decode against the opcode rules, plus directed corner cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  pc_addr;
    logic        zero_flag;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        halted;
    logic        fault;

    logic [15:0] rom [256];
    logic [15:0] sb [$];
    int          ack_delay;
    logic        ack_never;
    logic        force_ack;
    int          n_vec = 0;
    int          n_err = 0;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .pc_addr   (pc_addr),
        .zero_flag (zero_flag),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // program counter neighbour
    always @(posedge clk or negedge reset) begin
        if (!reset) pc_addr <= 8'h00;
        else if (pc_load) pc_addr <= pc_target;
        else if (pc_inc) pc_addr <= pc_addr + 8'h01;
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_op(input logic [3:0] op, input string tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ir_valid && ir[15:12] == op) begin
                hit = 1'b1;
                break;
            end
        end
        chk(hit, 1, tag);
    endtask

    // memory responder: acks on REQ cycle ack_delay+1 and records the word sent
    initial begin
        int n;
        n = 0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                n++;
                if (!ack_never && n == ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rom[mem_addr];
                    sb.push_back(rom[mem_addr]);
                end else begin
                    mem_ack = force_ack;
                end
            end else begin
                n = 0;
                mem_ack = force_ack;
            end
        end
    end

    // decode monitor
    initial begin
        logic [15:0] exp_ir;
        logic        exp_inc;
        logic        exp_load;
        forever begin
            @(negedge clk);
            if (ir_valid) begin
                chk(sb.size() > 0, 1, "sb_nonempty");
                if (sb.size() > 0) begin
                    exp_ir = sb.pop_front();
                    case (exp_ir[15:12])
                        4'hC:    begin exp_load = 1'b1;      exp_inc = 1'b0;       end
                        4'hD:    begin exp_load = zero_flag; exp_inc = !zero_flag; end
                        4'hF:    begin exp_load = 1'b0;      exp_inc = 1'b0;       end
                        default: begin exp_load = 1'b0;      exp_inc = 1'b1;       end
                    endcase
                    chk(ir, exp_ir, "dec_ir");
                    chk(pc_inc, exp_inc, "dec_pc_inc");
                    chk(pc_load, exp_load, "dec_pc_load");
                    chk(pc_target, exp_ir[7:0], "dec_target");
                end
            end else begin
                chk({pc_inc, pc_load}, 0, "no_pulse_outside_decode");
            end
        end
    end

    initial begin
        reset = 1'b0; run = 1'b0; zero_flag = 1'b0;
        ack_delay = 0; ack_never = 1'b0; force_ack = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h1000; rom[8'h01] = 16'h2000; rom[8'h02] = 16'h3000;
        rom[8'h03] = 16'hC010; rom[8'h10] = 16'hD040; rom[8'h11] = 16'hD040;
        rom[8'h40] = 16'hE123; rom[8'h41] = 16'hF000;

        // reset state
        @(negedge clk);
        chk(mem_req, 0, "rst_mem_req");   chk(ir, 0, "rst_ir");
        chk(ir_valid, 0, "rst_ir_valid"); chk(pc_inc, 0, "rst_pc_inc");
        chk(pc_load, 0, "rst_pc_load");   chk(halted, 0, "rst_halted");
        chk(fault, 0, "rst_fault");       chk(pc_target, 0, "rst_target");
        chk(mem_addr, 0, "rst_mem_addr");
        reset = 1'b1;
        @(negedge clk);
        chk(mem_req, 0, "idle_no_req");
        run = 1'b1;

        // straight-line fetch, immediate ack
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(mem_req, (i % 2 == 0) ? 1 : 0, "alt_req");
        end
        @(negedge clk);
        chk(pc_addr, 3, "pc_after_three");
        chk(mem_addr, 3, "mem_addr_three");

        // JMP 0x10
        wait_op(4'hC, "wait_jmp");
        chk(pc_inc, 0, "jmp_no_inc");
        chk(pc_target, 8'h10, "jmp_target");
        @(negedge clk);
        chk(mem_req, 1, "jmp_next_req");
        chk(mem_addr, 8'h10, "jmp_next_addr");

        // JZ 0x40 not taken then taken
        wait_op(4'hD, "wait_jz0");
        chk(pc_inc, 1, "jz0_inc");
        @(negedge clk);
        zero_flag = 1'b1;
        wait_op(4'hD, "wait_jz1");
        chk(pc_load, 1, "jz1_load");
        chk(pc_target, 8'h40, "jz1_target");
        @(negedge clk);
        zero_flag = 1'b0;
        chk(mem_addr, 8'h40, "jz1_next_addr");

        // HALT
        begin
            logic hit;
            hit = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (halted) begin hit = 1'b1; break; end
            end
            chk(hit, 1, "wait_halt");
        end
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk({halted, mem_req}, 2'b10, "halt_sticky");
        end
        chk(pc_addr, 8'h41, "halt_pc_hold");
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk(halted, 0, "halt_clear");
        @(negedge clk);
        run = 1'b0;
        reset = 1'b1;

        // timeout with no ack
        ack_never = 1'b1;
        @(negedge clk);
        run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk(mem_req, 1, "to_req");
        end
        chk(fault, 0, "to_not_yet");
        @(negedge clk);
        chk(fault, 1, "to_fault");
        chk(mem_req, 0, "to_req_low");
        @(negedge clk);
        chk(fault, 1, "to_fault_sticky");
        reset = 1'b0; run = 1'b0; ack_never = 1'b0;
        #1;
        chk(fault, 0, "to_fault_clear");
        @(negedge clk);
        reset = 1'b1;

        // ack on the last allowed cycle wins
        rom[8'h00] = 16'h2ABC;
        ack_delay = 14;
        @(negedge clk);
        run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk(mem_req, 1, "late_req");
        end
        @(negedge clk);
        run = 1'b0;
        chk(ir_valid, 1, "late_decode");
        chk(fault, 0, "late_no_fault");
        chk(ir, 16'h2ABC, "late_ir");
        @(negedge clk);
        chk(mem_req, 0, "late_idle");
        chk(fault, 0, "late_no_fault2");

        // asynchronous reset in the middle of REQ
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rom[8'h00] = 16'h3055;
        ack_delay = 0;
        @(negedge clk);
        run = 1'b1;
        wait_op(4'h3, "wait_pre_rst");
        ack_never = 1'b1;
        @(negedge clk);
        chk(mem_req, 1, "mid_req");
        chk(ir, 16'h3055, "mid_ir");
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk(mem_req, 0, "async_req");
        chk(ir, 0, "async_ir");
        chk(ir_valid, 0, "async_ir_valid");
        force_ack = 1'b1;
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ack_never = 1'b0;
        @(negedge clk);
        chk(mem_req, 0, "post_rst_req");
        chk(ir, 0, "post_rst_ir");
        chk(ir_valid, 0, "post_rst_ir_valid");

        // drop run during a 3-cycle ack wait
        rom[8'h00] = 16'h4111;
        ack_delay = 3;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk(mem_req, 1, "drop_req1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({mem_req, ir_valid}, 2'b10, "drop_wait");
        end
        @(negedge clk);
        chk(ir_valid, 1, "drop_decode");
        chk(pc_inc, 1, "drop_inc");
        chk(ir, 16'h4111, "drop_ir");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(mem_req, 0, "drop_idle");
        end

        chk(sb.size(), 0, "sb_drained");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch/decode sequencer that consumes the address produced by the program counter `pc`. It reads one instruction per address from instruction memory over a req/ack handshake and latches it into the instruction register. It decodes control flow and drives the PC's increment/load controls back. It sits between `pc` and the instruction ROM in the simple computer datapath.

## Interface
- `ADDR_W`, 8, PC/memory address width (matches `pc` count width)
- `INSTR_W`, 16, instruction width
- `TIMEOUT`, 15, max cycles waiting for `mem_ack` before fault (≥1)

- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low reset (0 = reset asserted)
- `run` in 1 — enable fetching
- `pc_addr` in ADDR_W — current PC value
- `zero_flag` in 1 — ALU zero flag for conditional jump
- `mem_req` out 1 — read request
- `mem_addr` out ADDR_W — read address; equals `pc_addr` continuously, meaningful when `mem_req`=1
- `mem_ack` in 1 — memory data valid
- `mem_rdata` in INSTR_W — instruction word
- `ir` out INSTR_W — instruction register
- `ir_valid` out 1 — one-cycle pulse, `ir` newly decoded
- `pc_inc` out 1 — one-cycle pulse, PC += 1
- `pc_load` out 1 — one-cycle pulse, PC ← `pc_target`
- `pc_target` out ADDR_W — jump target (`ir[7:0]`)
- `halted` out 1 — HALT executed (sticky)
- `fault` out 1 — memory timeout (sticky)

## Operation
- Instruction format: `ir[15:12]` opcode, `ir[11:8]` register field (pass-through), `ir[7:0]` immediate/address.
- Opcodes: 0xC JMP → `pc_load`. 0xD JZ → `pc_load` if `zero_flag`=1 in DECODE cycle, else `pc_inc`. 0xF HALT → no PC pulse, enter HALT. All others (0x0–0xB, 0xE) → `pc_inc`.
- FSM states: IDLE, REQ, DECODE, HALT, FAULT.
  - IDLE: outputs quiet; `run`=1 → REQ.
  - REQ: `mem_req`=1; wait counter increments each cycle without ack.
    - `mem_ack`=1 sampled at edge: `ir` ← `mem_rdata`, counter cleared → DECODE.
    - Counter reaches TIMEOUT with no ack → FAULT.
  - DECODE: one cycle, `ir_valid`=1 plus exactly one of `pc_inc`/`pc_load` (none for HALT).
    - Next state: HALT if opcode 0xF; else REQ if `run`=1; else IDLE.
  - HALT: `halted`=1; exit only by reset.
  - FAULT: `fault`=1, `mem_req`=0; exit only by reset.
- `pc_inc` and `pc_load` are never high together.
- `pc_target` is driven from `ir[7:0]` at all times.
- `run` deassertion during REQ does not abort the transaction; the instruction completes, then the FSM goes to IDLE.
- PC wrap (0xFF+1 → 0x00) is the PC's responsibility; fetch continues normally across the wrap.

## Timing
- Reset (`reset`=0) asynchronously forces state IDLE and drives every output to 0: `ir`=0, `ir_valid`, `pc_inc`, `pc_load`, `mem_req`, `halted`, `fault` all 0, wait counter 0. `mem_addr` and `pc_target` follow their sources (`pc_addr` and `ir[7:0]`=0).
- Reset mid-REQ: `mem_req` drops immediately with no completion, and any ack arriving while reset is asserted is ignored.
- After reset release, the first REQ cycle is the cycle after the first edge with `run`=1.
- Handshake: `mem_req` is held high until the edge at which `mem_ack`=1 is sampled. `mem_req` is low in the following cycle (DECODE). Acks received outside REQ are ignored.
- Latency: ack in the first REQ cycle gives 2 cycles per instruction (REQ, DECODE). Each ack wait cycle adds 1.
- PC contract: the PC updates on the edge ending DECODE, so `mem_addr` is the new address in the next REQ cycle.
- Timeout: FAULT is entered on the edge ending the TIMEOUT-th consecutive REQ cycle without ack. An ack sampled on that same edge wins (DECODE, no fault).

## Test plan
- Reset then `run`=1, memory acks immediately, ROM[0..2]=0x1000,0x2000,0x3000 → `mem_req` high every other cycle, `ir` takes the three values, three `pc_inc` pulses, `pc_addr` 0→3.
- ROM[3]=0xC010 (JMP 0x10) → `pc_load`=1 with `pc_target`=0x10, `pc_inc`=0 in that cycle, next `mem_addr`=0x10.
- JZ 0x40 executed twice, first with `zero_flag`=0 then with `zero_flag`=1 → first gives `pc_inc`, second gives `pc_load` with target 0x40.
- ROM[n]=0xF000 → `halted`=1 and `mem_req` stays 0 for 20+ cycles with `run`=1; pulsing `reset`=0 clears `halted`.
- Memory withholds ack for 15 cycles with TIMEOUT=15 → `fault`=1 and `mem_req`=0. A separate run with ack on the 15th cycle → normal DECODE, `fault`=0.
- `reset`=0 asserted mid-REQ between clock edges → `mem_req`, `ir`, `ir_valid` go 0 immediately. Drop `run` during a 3-cycle ack wait → instruction completes, then IDLE.
